// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM state
// encoding and the byte-lane select rule used by the lane aligner.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_RESP
  } state_e;

  // Loads always read the whole word; stores enable only the lanes they touch.
  function automatic logic [3:0] lane_sel(input logic we, input logic [2:0] funct3,
                                          input logic [1:0] off);
    logic [3:0] sel;
    sel = 4'b1111;
    if (we) begin
      case (funct3[1:0])
        2'b00:   sel = 4'b0001 << off;
        2'b01:   sel = off[1] ? 4'b1100 : 4'b0011;
        default: sel = 4'b1111;
      endcase
    end
    return sel;
  endfunction

  function automatic logic f3_legal(input logic we, input logic [2:0] funct3);
    if (we) return funct3 <= F3_W;
    return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
           (funct3 == F3_BU) || (funct3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational datapath: store lane enables and replicated store data, plus
// load extraction (shift by byte offset) with sign or zero extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  sel,
  output logic [31:0] wlanes,
  output logic [31:0] rdata
);

  logic [31:0] shifted;

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    sel     = lane_sel(we, funct3, off);
    wlanes  = '0;
    shifted = rword >> {off, 3'b000};
    rdata   = rword;
    if (we) begin
      case (funct3[1:0])
        2'b00:   wlanes = {4{wdata[7:0]}};
        2'b01:   wlanes = {2{wdata[15:0]}};
        default: wlanes = wdata;
      endcase
    end
    case (funct3)
      F3_B:    rdata = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    rdata = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   rdata = {24'h0, shifted[7:0]};
      F3_HU:   rdata = {16'h0, shifted[15:0]};
      default: rdata = rword;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, IDLE->ACCESS->WAIT->RESP.
// Optional build macro MISALIGN_TRAP_EN traps misaligned H/W accesses instead of aligning them.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int READ_LAT  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addy,
  output logic [31:0] mem_datain,
  output logic        mem_wen,
  output logic        mem_ren,
  output logic [3:0]  mem_byte_selector,
  input  logic [31:0] mem_dataout
);

  localparam logic [2:0] LAT = 3'(READ_LAT);

  if (READ_LAT < 1 || READ_LAT > 4 || MEM_WORDS < 1) begin : g_param_check
    $error("load_store_unit: READ_LAT must be 1..4 and MEM_WORDS positive");
  end

  state_e      state_q, state_d;
  logic        we_q, we_d, err_q, err_d;
  logic [2:0]  f3_q, f3_d, cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;

  logic        req_err, strobe;
  logic [31:0] req_addr_eff, load_data, wlanes;
  logic [3:0]  sel;

  // Misaligned halfword/word requests are either trapped or forced aligned.
  always_comb begin
    req_addr_eff = req_addr;
    if (req_funct3[1:0] == 2'b01)      req_addr_eff[0]   = 1'b0;
    else if (req_funct3[1:0] == 2'b10) req_addr_eff[1:0] = 2'b00;
`ifdef MISALIGN_TRAP_EN
    req_err = !f3_legal(req_we, req_funct3) ||
              (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
              (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
`else
    req_err = !f3_legal(req_we, req_funct3);
`endif
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    err_d   = err_q;
    f3_d    = f3_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: if (req_valid) begin
        we_d    = req_we;
        err_d   = req_err;
        f3_d    = req_funct3;
        addr_d  = req_addr_eff;
        wdata_d = req_wdata;
        rdata_d = '0;
        cnt_d   = 3'd1;
        state_d = req_err ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS, ST_WAIT: begin
        if (we_q) begin
          state_d = ST_RESP;
        end else if (cnt_q == LAT) begin
          state_d = ST_RESP;
          rdata_d = load_data;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = cnt_q + 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      err_q   <= err_d;
      f3_q    <= f3_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  lsu_lane_align u_align (
    .we     (we_q),
    .funct3 (f3_q),
    .off    (addr_q[1:0]),
    .wdata  (wdata_q),
    .rword  (mem_dataout),
    .sel    (sel),
    .wlanes (wlanes),
    .rdata  (load_data)
  );

  // Address, lanes and data are only driven while a strobe is active.
  assign strobe            = (state_q == ST_ACCESS) || (state_q == ST_WAIT);
  assign mem_wen           = strobe && we_q;
  assign mem_ren           = strobe && !we_q;
  assign mem_addy          = strobe ? {2'b00, addr_q[31:2]} : '0;
  assign mem_byte_selector = strobe ? sel : '0;
  assign mem_datain        = strobe ? wlanes : '0;
  assign req_ready         = (state_q == ST_IDLE);
  assign resp_valid        = (state_q == ST_RESP);
  assign resp_err          = resp_valid && err_q;
  assign resp_rdata        = resp_valid ? rdata_q : '0;

endmodule
